ssd_mux_driver: RTL and testbench

//  Time-multiplexed driver for NUM_DIGITS common-segment seven-segment digits, each showing one hex nibble.

---
 rtl/ssd_mux_driver.sv | 151 +++++++++++++++
 tb/tb_ssd_mux_driver.sv | 176 +++++++++++++++++
 2 files changed

// File: rtl/ssd_mux_driver.sv
// Time-multiplexed seven-segment driver: refresh scan, double-buffered value,
// decimal points, leading-zero blanking and an anti-ghosting blank per slot.

module ssd_digit_lane (
  input  logic [3:0] nib,
  input  logic       zero_above,
  output logic [6:0] seg,
  output logic       zero_from_here
);
  always_comb begin
    seg = 7'h00;
    case (nib)
      4'h0: seg = 7'h3F;
      4'h1: seg = 7'h06;
      4'h2: seg = 7'h5B;
      4'h3: seg = 7'h4F;
      4'h4: seg = 7'h66;
      4'h5: seg = 7'h6D;
      4'h6: seg = 7'h7D;
      4'h7: seg = 7'h07;
      4'h8: seg = 7'h7F;
      4'h9: seg = 7'h6F;
      4'hA: seg = 7'h77;
      4'hB: seg = 7'h7C;
      4'hC: seg = 7'h39;
      4'hD: seg = 7'h5E;
      4'hE: seg = 7'h79;
      4'hF: seg = 7'h71;
      default: seg = 7'h00;
    endcase
  end

  // Zero run from the most significant digit down to this one
  assign zero_from_here = zero_above && (nib == 4'h0);
endmodule

module ssd_mux_driver #(
  parameter int NUM_DIGITS       = 4,
  parameter int REFRESH_DIV      = 50000,
  parameter int BLANK_CYCLES     = 16,
  parameter int ANODE_ACTIVE_LOW = 1,
  parameter int SEG_ACTIVE_LOW   = 0,
  localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    enable,
  input  logic                    load,
  input  logic [4*NUM_DIGITS-1:0] value_in,
  input  logic [NUM_DIGITS-1:0]   dp_in,
  input  logic                    blank_lz,
  output logic [6:0]              ssd_out,
  output logic                    dp_out,
  output logic [NUM_DIGITS-1:0]   digit_sel,
  output logic [IDX_W-1:0]        digit_idx,
  output logic                    frame_done
);
  localparam int CNT_W   = $clog2(REFRESH_DIV);
  localparam bit SEG_INV = (SEG_ACTIVE_LOW != 0);
  localparam bit AN_INV  = (ANODE_ACTIVE_LOW != 0);

  logic [CNT_W-1:0]        cnt;
  logic [IDX_W-1:0]        idx;
  logic [4*NUM_DIGITS-1:0] shadow, disp;
  logic [NUM_DIGITS-1:0]   shadow_dp, disp_dp;
  logic                    pending;

  logic slot_end, boundary, in_blank, lit, lz_blank;
  logic [NUM_DIGITS-1:0][6:0] lane_seg;
  logic [NUM_DIGITS:0]        zero_chain;
  logic [6:0]                 seg_nxt;
  logic                       dp_nxt;
  logic [NUM_DIGITS-1:0]      sel_nxt;

  assign slot_end = (cnt == CNT_W'(REFRESH_DIV - 1));
  assign boundary = slot_end && (idx == IDX_W'(NUM_DIGITS - 1));

  generate
    if (BLANK_CYCLES == 0) begin : g_no_blank
      assign in_blank = 1'b0;
    end else begin : g_blank
      assign in_blank = (cnt < CNT_W'(BLANK_CYCLES));
    end
  endgenerate

  assign zero_chain[NUM_DIGITS] = 1'b1;
  generate
    for (genvar k = 0; k < NUM_DIGITS; k++) begin : g_lane
      ssd_digit_lane u_lane (
        .nib            (disp[4*k +: 4]),
        .zero_above     (zero_chain[k+1]),
        .seg            (lane_seg[k]),
        .zero_from_here (zero_chain[k])
      );
    end
  endgenerate

  // Digit 0 always shows, even when the whole value is zero
  assign lz_blank = blank_lz && zero_chain[idx] && (idx != '0);
  assign lit      = enable && !in_blank;
  assign seg_nxt  = (lit && !lz_blank) ? lane_seg[idx] : 7'h00;
  assign dp_nxt   = lit && disp_dp[idx];
  assign sel_nxt  = lit ? (NUM_DIGITS'(1) << idx) : '0;

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt       <= '0;
      idx       <= '0;
      shadow    <= '0;
      shadow_dp <= '0;
      disp      <= '0;
      disp_dp   <= '0;
      pending   <= 1'b0;
    end else begin
      cnt <= slot_end ? '0 : cnt + CNT_W'(1);
      if (slot_end)
        idx <= (idx == IDX_W'(NUM_DIGITS - 1)) ? '0 : idx + IDX_W'(1);

      // Display only moves at a frame boundary; a load on that very cycle bypasses the shadow
      if (boundary && load) begin
        disp    <= value_in;
        disp_dp <= dp_in;
        pending <= 1'b0;
      end else if (boundary && pending) begin
        disp    <= shadow;
        disp_dp <= shadow_dp;
        pending <= 1'b0;
      end else if (load) begin
        shadow    <= value_in;
        shadow_dp <= dp_in;
        pending   <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ssd_out    <= {7{SEG_INV}};
      dp_out     <= SEG_INV;
      digit_sel  <= {NUM_DIGITS{AN_INV}};
      digit_idx  <= '0;
      frame_done <= 1'b0;
    end else begin
      ssd_out    <= seg_nxt ^ {7{SEG_INV}};
      dp_out     <= dp_nxt ^ SEG_INV;
      digit_sel  <= sel_nxt ^ {NUM_DIGITS{AN_INV}};
      digit_idx  <= idx;
      frame_done <= boundary;
    end
  end
endmodule

// File: tb/tb_ssd_mux_driver.sv
// Directed plus randomized checks of ssd_mux_driver against a frame/slot model
// driven by elapsed cycles since reset.
module tb_ssd_mux_driver;
  localparam int N = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        enable = 1'b0;
  logic        load = 1'b0;
  logic        blank_lz = 1'b0;
  logic [15:0] value_in = '0;
  logic [3:0]  dp_in = '0;
  logic [6:0]  ssd_out;
  logic        dp_out;
  logic [3:0]  digit_sel;
  logic [1:0]  digit_idx;
  logic        frame_done;

  int checks = 0;
  int failures = 0;

  logic [6:0] hex [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                           7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};

  // Model state: cycles since reset, shown value, buffered value
  int unsigned t = 0;
  logic [15:0] m_disp = '0, m_shadow = '0;
  logic [3:0]  m_dp = '0, m_sdp = '0;
  bit          m_pend = 0;

  ssd_mux_driver #(
    .NUM_DIGITS(N), .REFRESH_DIV(4), .BLANK_CYCLES(1),
    .ANODE_ACTIVE_LOW(1), .SEG_ACTIVE_LOW(0)
  ) dut (
    .clk(clk), .rst(rst), .enable(enable), .load(load), .value_in(value_in),
    .dp_in(dp_in), .blank_lz(blank_lz), .ssd_out(ssd_out), .dp_out(dp_out),
    .digit_sel(digit_sel), .digit_idx(digit_idx), .frame_done(frame_done)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s t=%0d observed=%0h expected=%0h", tag, t, obs, exp);
    end
  endtask

  // One clock: predict outputs from pre-edge state, advance model, compare after edge
  task automatic step();
    logic [6:0] e_seg;
    logic       e_dp, e_fd;
    logic [3:0] e_sel;
    logic [1:0] e_idx;
    logic [15:0] upper;
    int ph, c, d;
    bit lit, blank, bnd;
    if (rst) begin
      e_seg = '0; e_dp = 0; e_sel = 4'hF; e_idx = '0; e_fd = 0;
    end else begin
      ph = int'(t % 16); c = ph % 4; d = ph / 4;
      lit   = enable && (c >= 1);
      upper = m_disp >> (4 * d);
      blank = blank_lz && (d != 0) && (upper == 16'h0);
      e_sel = lit ? 4'(~(4'b0001 << d)) : 4'hF;
      e_seg = (lit && !blank) ? hex[m_disp[4*d +: 4]] : 7'h00;
      e_dp  = lit ? m_dp[d] : 1'b0;
      e_idx = 2'(d);
      e_fd  = (ph == 15);
    end
    if (rst) begin
      t = 0; m_disp = '0; m_dp = '0; m_shadow = '0; m_sdp = '0; m_pend = 0;
    end else begin
      bnd = ((t % 16) == 15);
      if (bnd && load) begin
        m_disp = value_in; m_dp = dp_in; m_pend = 0;
      end else if (bnd && m_pend) begin
        m_disp = m_shadow; m_dp = m_sdp; m_pend = 0;
      end else if (load) begin
        m_shadow = value_in; m_sdp = dp_in; m_pend = 1;
      end
      t++;
    end
    @(posedge clk);
    #1;
    check("ssd_out", 32'(ssd_out), 32'(e_seg));
    check("dp_out", 32'(dp_out), 32'(e_dp));
    check("digit_sel", 32'(digit_sel), 32'(e_sel));
    check("digit_idx", 32'(digit_idx), 32'(e_idx));
    check("frame_done", 32'(frame_done), 32'(e_fd));
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic wait_phase(input int ph);
    for (int i = 0; i < 32 && int'(t % 16) != ph; i++) step();
  endtask

  task automatic load_now(input logic [15:0] v, input logic [3:0] dp);
    value_in = v; dp_in = dp; load = 1'b1;
    step();
    load = 1'b0;
  endtask

  initial begin
    logic [15:0] vals [4] = '{16'h3210, 16'h7654, 16'hBA98, 16'hFEDC};
    logic [15:0] mask;

    // Reset then free-running scan of the all-zero display
    rst = 1'b1;
    run(3);
    rst = 1'b0; enable = 1'b1;
    run(20);

    // All sixteen codes, each value loaded on a boundary cycle
    for (int i = 0; i < 4; i++) begin
      wait_phase(15);
      load_now(vals[i], 4'(i + 5));
      run(15);
    end

    // Mid-frame load, overwrite before boundary, then load on the boundary itself
    wait_phase(5);
    load_now(16'h1234, 4'b0011);
    run(5);
    load_now(16'h5678, 4'b0100);
    wait_phase(15);
    load_now(16'h9ABC, 4'b1001);
    run(16);

    // Leading-zero blanking
    blank_lz = 1'b1;
    wait_phase(15);
    load_now(16'h0050, 4'b1000);
    run(16);
    wait_phase(15);
    load_now(16'h0000, 4'b0000);
    run(16);

    // Disable for two frames, then resume mid-scan
    load_now(16'h4321, 4'b0101);
    wait_phase(6);
    enable = 1'b0;
    run(32);
    enable = 1'b1;
    run(16);

    // Reset at idx=2 with a pending load
    wait_phase(7);
    load_now(16'hABCD, 4'b1111);
    rst = 1'b1;
    step();
    rst = 1'b0;
    run(20);

    // Randomized traffic
    for (int i = 0; i < 800; i++) begin
      mask     = 16'hFFFF >> (4 * ($urandom % 4));
      value_in = 16'($urandom) & mask;
      dp_in    = 4'($urandom);
      load     = ($urandom % 8) == 0;
      enable   = ($urandom % 16) != 0;
      blank_lz = 1'($urandom);
      rst      = ($urandom % 250) == 0;
      step();
    end
    load = 1'b0; rst = 1'b0;
    run(4);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
